snake_mover: RTL and testbench

SNAKE_MOVER -- requirements
Module: snake_mover

---
 rtl/snake_mover.sv | 178 +++++++++++++++++
 tb/tb_snake_mover.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_mover.sv
// snake_mover: owns the snake body for a grid game. The body is held as
// MAX_LEN (x,y) segment registers with segment 0 as the head. On each
// accepted step the next head is computed from the pending direction,
// checked against the walls, the food cell and the body, then either
// committed (body shifts by one) or refused with a collision pulse.
//
// Handshake: move_enable is a single-cycle strobe. A step is accepted
// when state==PLAYING, move_enable==1 and the snake is not dead. Its
// results (head, length, pulses) are visible the cycle after the strobe.
// dir_valid qualifies dir_req on the same cycle; there is no
// back-pressure, and the last legal request before a step wins.
module snake_mover #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3,
  parameter int START_X   = 16,
  parameter int START_Y   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  input  logic       move_enable,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic [5:0] food_x,
  input  logic [5:0] food_y,
  input  logic [5:0] query_x,
  input  logic [5:0] query_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] length,
  output logic       wall_collision,
  output logic       self_collision,
  output logic       food_eaten,
  output logic       query_hit
);

  localparam logic [1:0] GAME_IDLE    = 2'b00;
  localparam logic [1:0] GAME_PLAYING = 2'b01;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  logic [5:0] seg_x [MAX_LEN];
  logic [5:0] seg_y [MAX_LEN];
  dir_t       cur_dir;
  dir_t       nxt_dir;
  logic       dead;

  logic [5:0] next_x;
  logic [5:0] next_y;
  logic       hit_wall;
  logic       hit_food;
  logic       hit_self;
  logic [5:0] self_limit;
  logic       step;

  // Opposite direction flips bit 1: up<->down, right<->left.
  function automatic dir_t reverse_of(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign step   = (state == GAME_PLAYING) && move_enable && !dead;

  // Next head cell from the pending direction; a step off the grid is
  // flagged rather than wrapped, and the head coordinate is held.
  always_comb begin
    next_x   = seg_x[0];
    next_y   = seg_y[0];
    hit_wall = 1'b0;
    case (nxt_dir)
      DIR_UP: begin
        if (seg_y[0] == 6'd0) hit_wall = 1'b1;
        else                  next_y   = seg_y[0] - 6'd1;
      end
      DIR_RIGHT: begin
        if (seg_x[0] >= 6'(GRID_W - 1)) hit_wall = 1'b1;
        else                            next_x   = seg_x[0] + 6'd1;
      end
      DIR_DOWN: begin
        if (seg_y[0] >= 6'(GRID_H - 1)) hit_wall = 1'b1;
        else                            next_y   = seg_y[0] + 6'd1;
      end
      default: begin
        if (seg_x[0] == 6'd0) hit_wall = 1'b1;
        else                  next_x   = seg_x[0] - 6'd1;
      end
    endcase
  end

  // Food and body tests. The tail normally vacates its cell on a step,
  // so it only counts as an obstacle when eating (the body grows and the
  // tail stays put).
  always_comb begin
    hit_food   = (next_x == food_x) && (next_y == food_y);
    self_limit = hit_food ? {1'b0, length} : ({1'b0, length} - 6'd1);
    hit_self   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < self_limit) && (seg_x[i] == next_x) && (seg_y[i] == next_y))
        hit_self = 1'b1;
    end
  end

  // Renderer lookup: only segments below the current length are live.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < length) && (seg_x[i] == query_x) && (seg_y[i] == query_y))
        query_hit = 1'b1;
    end
  end

  // Body, length, direction, dead flag and pulses. Reset and IDLE both
  // lay the snake out horizontally to the left of the start cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(START_X - i);
        seg_y[i] <= 6'(START_Y);
      end
      length         <= 5'(START_LEN);
      cur_dir        <= DIR_RIGHT;
      nxt_dir        <= DIR_RIGHT;
      dead           <= 1'b0;
      wall_collision <= 1'b0;
      self_collision <= 1'b0;
      food_eaten     <= 1'b0;
    end else if (state == GAME_IDLE) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'(START_X - i);
        seg_y[i] <= 6'(START_Y);
      end
      length         <= 5'(START_LEN);
      cur_dir        <= DIR_RIGHT;
      nxt_dir        <= DIR_RIGHT;
      dead           <= 1'b0;
      wall_collision <= 1'b0;
      self_collision <= 1'b0;
      food_eaten     <= 1'b0;
    end else begin
      wall_collision <= 1'b0;
      self_collision <= 1'b0;
      food_eaten     <= 1'b0;
      if (step) begin
        if (hit_wall) begin
          wall_collision <= 1'b1;
          dead           <= 1'b1;
        end else if (hit_self) begin
          self_collision <= 1'b1;
          dead           <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= next_x;
          seg_y[0] <= next_y;
          cur_dir  <= nxt_dir;
          if (hit_food) begin
            food_eaten <= 1'b1;
            if (length < 5'(MAX_LEN)) length <= length + 5'd1;
          end
        end
      end
      // Reversal is judged against the committed direction.
      if (dir_valid && (dir_t'(dir_req) != reverse_of(cur_dir)))
        nxt_dir <= dir_t'(dir_req);
    end
  end

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover with hand-computed expectations.
module tb_snake_mover;

  logic       clk;
  logic       reset;
  logic [1:0] state;
  logic       move_enable;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic [5:0] food_x, food_y;
  logic [5:0] query_x, query_y;
  logic [5:0] head_x, head_y;
  logic [4:0] length;
  logic       wall_collision, self_collision, food_eaten, query_hit;

  int checks;
  int errors;

  snake_mover dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .move_enable    (move_enable),
    .dir_valid      (dir_valid),
    .dir_req        (dir_req),
    .food_x         (food_x),
    .food_y         (food_y),
    .query_x        (query_x),
    .query_y        (query_y),
    .head_x         (head_x),
    .head_y         (head_y),
    .length         (length),
    .wall_collision (wall_collision),
    .self_collision (self_collision),
    .food_eaten     (food_eaten),
    .query_hit      (query_hit)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge after the capturing edge.
  task automatic do_step();
    @(negedge clk);
    move_enable = 1'b1;
    @(negedge clk);
    move_enable = 1'b0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_req   = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    state = 2'b00;
    @(negedge clk);
    state = 2'b01;
  endtask

  task automatic set_food(input int x, input int y);
    food_x = 6'(x);
    food_y = 6'(y);
  endtask

  function automatic logic [2:0] pulses();
    return {wall_collision, self_collision, food_eaten};
  endfunction

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    state       = 2'b00;
    move_enable = 1'b0;
    dir_valid   = 1'b0;
    dir_req     = 2'b00;
    set_food(0, 23);
    query_x     = 6'd15;
    query_y     = 6'd12;

    // reset state
    #1;
    check("rst_head_x", head_x, 16);
    check("rst_head_y", head_y, 12);
    check("rst_length", length, 3);
    check("rst_pulses", pulses(), 0);
    check("rst_query_seg2", query_hit, 1);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    query_x = 6'd13;
    #1;
    check("query_beyond_len", query_hit, 0);

    // single plain step
    @(negedge clk);
    state = 2'b01;
    do_step();
    check("step1_head_x", head_x, 17);
    check("step1_head_y", head_y, 12);
    check("step1_length", length, 3);
    check("step1_pulses", pulses(), 0);

    // reversal ignored, then turn up
    set_dir(2'b11);
    do_step();
    check("rev_head_x", head_x, 18);
    check("rev_head_y", head_y, 12);
    set_dir(2'b00);
    do_step();
    check("up_head_x", head_x, 18);
    check("up_head_y", head_y, 11);

    // eating grows the body, tail retained
    go_idle();
    set_food(17, 12);
    do_step();
    check("eat_pulse", food_eaten, 1);
    check("eat_length", length, 4);
    check("eat_head_x", head_x, 17);
    query_x = 6'd14;
    query_y = 6'd12;
    #1;
    check("eat_tail_kept", query_hit, 1);
    @(negedge clk);
    check("eat_pulse_clear", food_eaten, 0);
    check("eat_length_hold", length, 4);
    set_food(0, 23);

    // wall collision at the right edge
    go_idle();
    set_dir(2'b00);
    repeat (7) do_step();
    check("path_head_y", head_y, 5);
    set_dir(2'b01);
    repeat (15) do_step();
    check("edge_head_x", head_x, 31);
    check("edge_head_y", head_y, 5);
    do_step();
    check("wall_pulse", wall_collision, 1);
    check("wall_other_pulses", {self_collision, food_eaten}, 0);
    check("wall_head_x", head_x, 31);
    check("wall_head_y", head_y, 5);
    @(negedge clk);
    check("wall_pulse_clear", wall_collision, 0);
    set_dir(2'b10);
    do_step();
    check("dead_head_y", head_y, 5);
    check("dead_pulses", pulses(), 0);
    go_idle();
    check("idle_head_x", head_x, 16);
    check("idle_head_y", head_y, 12);

    // self collision into segment 3 of a length-5 body
    go_idle();
    set_food(17, 12);
    do_step();
    set_food(18, 12);
    do_step();
    check("self_len5", length, 5);
    set_food(0, 23);
    set_dir(2'b10);
    do_step();
    set_dir(2'b11);
    do_step();
    check("loop_head_x", head_x, 17);
    check("loop_head_y", head_y, 13);
    set_dir(2'b00);
    do_step();
    check("self_pulse", self_collision, 1);
    check("self_no_wall_food", {wall_collision, food_eaten}, 0);
    check("self_head_y", head_y, 13);
    check("self_length", length, 5);
    do_step();
    check("self_dead_head_y", head_y, 13);

    // stepping into the vacating tail is legal
    go_idle();
    set_food(17, 12);
    do_step();
    set_food(0, 23);
    set_dir(2'b10);
    do_step();
    set_dir(2'b11);
    do_step();
    set_dir(2'b00);
    do_step();
    check("tail_head_x", head_x, 16);
    check("tail_head_y", head_y, 12);
    check("tail_pulses", pulses(), 0);
    check("tail_length", length, 4);

    // tail with food on it is a collision (tail does not vacate)
    go_idle();
    set_food(17, 12);
    do_step();
    set_food(0, 23);
    set_dir(2'b10);
    do_step();
    set_dir(2'b11);
    do_step();
    set_food(16, 12);
    set_dir(2'b00);
    do_step();
    check("tailfood_self", self_collision, 1);
    check("tailfood_no_eat", food_eaten, 0);
    check("tailfood_length", length, 4);
    check("tailfood_head_y", head_y, 13);

    // length saturation
    go_idle();
    for (int k = 0; k < 13; k++) begin
      set_food(17 + k, 12);
      do_step();
    end
    check("sat_length", length, 16);
    check("sat_head_x", head_x, 29);
    set_food(30, 12);
    do_step();
    check("sat_pulse", food_eaten, 1);
    check("sat_length_hold", length, 16);
    check("sat_head_x2", head_x, 30);

    // reset mid-step
    @(negedge clk);
    move_enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_head_x", head_x, 16);
    check("mid_rst_head_y", head_y, 12);
    check("mid_rst_length", length, 3);
    check("mid_rst_pulses", pulses(), 0);
    @(negedge clk);
    move_enable = 1'b0;
    reset       = 1'b0;
    set_food(0, 23);
    do_step();
    check("post_rst_head_x", head_x, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
